// File: rtl/ntt_pkg.sv
// Shared defaults, coefficient type, adapter state encoding and range helper for the NTT stream adapter.
package ntt_pkg;

  localparam int unsigned NTT_N = 256;
  localparam int unsigned NTT_W = 12;
  localparam int unsigned NTT_Q = 3329;

  typedef logic [NTT_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } adapter_state_e;

  function automatic logic coeff_in_range(coeff_t c);
    return 32'(c) < NTT_Q;
  endfunction

endpackage

// File: rtl/ntt_coeff_buf.sv
// N x W coefficient store: single-entry write, single-cycle parallel load (wins over the write),
// combinational single-entry read and a flattened view with entry i at bits [i*W +: W].
module ntt_coeff_buf
  import ntt_pkg::*;
#(
  parameter int unsigned N = NTT_N,
  parameter int unsigned W = NTT_W,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_idx,
  input  logic [W-1:0]   wr_data,
  input  logic           load_en,
  input  logic [N*W-1:0] load_data,
  input  logic [CW-1:0]  rd_idx,
  output logic [W-1:0]   rd_data,
  output logic [N*W-1:0] flat
);

  logic [N-1:0][W-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (load_en) begin
      mem_q <= load_data;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign flat    = mem_q;

endmodule

// File: rtl/ntt_stream_adapter.sv
// Streams N coefficients into the NTT core buffer, starts the core 1 cycle after the last input beat,
// and drains the result 1 cycle after done; input is stalled outside LOAD, output holds while m_ready_i is low.
module ntt_stream_adapter
  import ntt_pkg::*;
#(
  parameter int unsigned N = NTT_N,
  parameter int unsigned W = NTT_W,
  parameter int unsigned Q = NTT_Q,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  input  logic [W-1:0]   s_data_i,
  input  logic           s_last_i,
  input  logic           mode_i,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic [W-1:0]   m_data_o,
  output logic           m_last_o,
  output logic           core_start_o,
  output logic           core_inv_o,
  input  logic           core_done_i,
  output logic [N*W-1:0] core_coeff_o,
  input  logic [N*W-1:0] core_coeff_i,
  input  logic           err_clr_i,
  output logic           err_len_o,
  output logic           err_range_o,
  output logic           busy_o
);

  adapter_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           mode_q;
  logic           s_hs, m_hs, at_end, core_load;
  logic           range_bad, len_bad;
  logic [W-1:0]   rd_data;

  assign at_end    = (cnt_q == CW'(N - 1));
  assign s_ready_o = (state_q == LOAD);
  assign s_hs      = s_valid_i && s_ready_o;
  assign m_valid_o = (state_q == UNLOAD);
  assign m_hs      = m_valid_o && m_ready_i;
  assign core_load = (state_q == WAIT) && core_done_i;

  assign m_data_o     = m_valid_o ? rd_data : '0;
  assign m_last_o     = m_valid_o && at_end;
  assign core_start_o = (state_q == START);
  assign core_inv_o   = ((state_q == START) || (state_q == WAIT)) && mode_q;
  assign busy_o       = (state_q != LOAD);

  // A length error is either an early last or a missing last on beat N-1.
  assign range_bad = s_hs && (32'(s_data_i) >= Q);
  assign len_bad   = s_hs && (s_last_i != at_end);

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (s_hs && at_end) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (core_done_i) state_d = UNLOAD;
      UNLOAD:  if (m_hs && at_end) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      err_len_o   <= 1'b0;
      err_range_o <= 1'b0;
    end else begin
      state_q <= state_d;

      // Early last discards the frame by rewinding; otherwise the counter wraps at N.
      if (s_hs) begin
        cnt_q <= (s_last_i || at_end) ? '0 : cnt_q + 1'b1;
      end else if (m_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (core_load) begin
        cnt_q <= '0;
      end

      if (s_hs && (cnt_q == '0)) mode_q <= mode_i;

      if (len_bad)        err_len_o <= 1'b1;
      else if (err_clr_i) err_len_o <= 1'b0;

      if (range_bad)      err_range_o <= 1'b1;
      else if (err_clr_i) err_range_o <= 1'b0;
    end
  end

  ntt_coeff_buf #(
    .N (N),
    .W (W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en     (s_hs),
    .wr_idx    (cnt_q),
    .wr_data   (s_data_i),
    .load_en   (core_load),
    .load_data (core_coeff_i),
    .rd_idx    (cnt_q),
    .rd_data   (rd_data),
    .flat      (core_coeff_o)
  );

endmodule

// File: tb/tb_ntt_stream_adapter.sv
// Self-checking bench: table of single-frame error scenarios, directed corner sequences and random frames
// checked against a frame-level model of the adapter plus a fixed-latency model of the NTT core.
module tb_ntt_stream_adapter;

  localparam int N = 256;
  localparam int W = 12;
  localparam int Q = 3329;
  localparam int CORE_LAT = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           s_valid_i, s_ready_o, s_last_i, mode_i;
  logic [W-1:0]   s_data_i;
  logic           m_valid_o, m_ready_i, m_last_o;
  logic [W-1:0]   m_data_o;
  logic           core_start_o, core_inv_o, core_done_i;
  logic [N*W-1:0] core_coeff_o, core_coeff_i;
  logic           err_clr_i, err_len_o, err_range_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;

  logic [W-1:0] tx      [N];
  logic [W-1:0] exp_arr [N];

  typedef struct {
    int val;
    int len;
    int last_final;
    int exp_range;
    int exp_len;
    int exp_start;
  } vec_t;

  vec_t vecs [7];

  always #5 clk_i = ~clk_i;

  ntt_stream_adapter #(.N(N), .W(W), .Q(Q)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .s_last_i     (s_last_i),
    .mode_i       (mode_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .core_start_o (core_start_o),
    .core_inv_o   (core_inv_o),
    .core_done_i  (core_done_i),
    .core_coeff_o (core_coeff_o),
    .core_coeff_i (core_coeff_i),
    .err_clr_i    (err_clr_i),
    .err_len_o    (err_len_o),
    .err_range_o  (err_range_o),
    .busy_o       (busy_o)
  );

  // Stand-in NTT core: forward result is 3328 - x, inverse adds 7, both modulo 2^W.
  function automatic logic [W-1:0] core_fn(input logic [W-1:0] x, input logic inv);
    int t;
    t = 3328 - int'(x) + (inv ? 7 : 0);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] dut_coeff(input int i);
    return core_coeff_o[i*W +: W];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_i) if (core_start_o === 1'b1) n_start++;

  initial begin : core_model
    logic [N*W-1:0] res;
    logic           inv;
    core_done_i  = 1'b0;
    core_coeff_i = '0;
    forever begin
      @(negedge clk_i);
      if (core_start_o === 1'b1) begin
        inv = core_inv_o;
        for (int i = 0; i < N; i++) res[i*W +: W] = core_fn(core_coeff_o[i*W +: W], inv);
        repeat (CORE_LAT) @(posedge clk_i);
        #2;
        core_coeff_i = res;
        core_done_i  = 1'b1;
        @(posedge clk_i);
        #2;
        core_done_i  = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < N; i++) if (dut_coeff(i) !== '0) nz++;
    check({tag, " s_ready_o"}, s_ready_o, 1);
    check({tag, " m_valid_o"}, m_valid_o, 0);
    check({tag, " m_last_o"}, m_last_o, 0);
    check({tag, " m_data_o"}, m_data_o, 0);
    check({tag, " core_start_o"}, core_start_o, 0);
    check({tag, " core_inv_o"}, core_inv_o, 0);
    check({tag, " err_len_o"}, err_len_o, 0);
    check({tag, " err_range_o"}, err_range_o, 0);
    check({tag, " busy_o"}, busy_o, 0);
    check({tag, " nonzero buffer entries"}, nz, 0);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  // Starts and ends on a negedge; mode_i is inverted after beat 0 so late sampling shows up.
  task automatic send_frame(input int len, input bit last_final, input bit mode, input bit gaps);
    int stuck;
    stuck = 0;
    for (int b = 0; b < len; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid_i = 1'b0;
          @(negedge clk_i);
        end
      end
      s_valid_i = 1'b1;
      s_data_i  = tx[b];
      s_last_i  = (b == len - 1) && last_final;
      mode_i    = (b == 0) ? mode : ~mode;
      for (int k = 0; k < 50 && s_ready_o !== 1'b1; k++) @(negedge clk_i);
      if (s_ready_o !== 1'b1) stuck++;
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check("input ready timeouts", stuck, 0);
  endtask

  // pat: 0 = always ready, 1 = ready every other cycle, 2 = random ready.
  task automatic drain(input bit mode, input int pat, output int cycles);
    int  idx, bad, stab_bad;
    bit  got_done, ready, stalled;
    logic [W-1:0] pd;
    logic         pl;
    got_done = 1'b0;
    cycles   = 0;
    for (int t = 0; t < 200 && !got_done; t++) begin
      @(negedge clk_i);
      if (t == 0) begin
        check("core_start_o single cycle", core_start_o, 0);
        check("core_inv_o during WAIT", core_inv_o, mode);
        check("s_ready_o low while busy", s_ready_o, 0);
      end
      if (core_done_i === 1'b1) begin
        got_done = 1'b1;
        check("m_valid_o low in done cycle", m_valid_o, 0);
      end
    end
    check("core done observed", got_done, 1);
    idx = 0; bad = 0; stab_bad = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
    for (int t = 0; t < 4 * N && idx < N; t++) begin
      @(negedge clk_i);
      cycles++;
      if (m_valid_o !== 1'b1 || m_data_o !== exp_arr[idx] ||
          m_last_o !== (idx == N - 1) || s_ready_o !== 1'b0) begin
        if (bad == 0)
          $display("first bad output beat %0d: valid=%0b data=%0d last=%0b, want data=%0d last=%0b",
                   idx, m_valid_o, m_data_o, m_last_o, exp_arr[idx], (idx == N - 1));
        bad++;
      end
      if (stalled && (m_data_o !== pd || m_last_o !== pl)) stab_bad++;
      case (pat)
        0:       ready = 1'b1;
        1:       ready = (t % 2 == 0);
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      m_ready_i = ready;
      pd      = m_data_o;
      pl      = m_last_o;
      stalled = !ready;
      if (ready && m_valid_o === 1'b1) idx++;
    end
    @(negedge clk_i);
    m_ready_i = 1'b0;
    check("output beats delivered", idx, N);
    check("bad output beats", bad, 0);
    check("output changed while stalled", stab_bad, 0);
    check("s_ready_o back after drain", s_ready_o, 1);
    check("m_valid_o low after drain", m_valid_o, 0);
  endtask

  task automatic run_frame(input bit last_final, input bit mode, input bit gaps, input int pat,
                           output int cycles);
    int bad;
    send_frame(N, last_final, mode, gaps);
    check("core_start_o 1 cycle after last beat", core_start_o, 1);
    bad = 0;
    for (int i = 0; i < N; i++) if (dut_coeff(i) !== tx[i]) bad++;
    check("core_coeff_o matches loaded frame", bad, 0);
    for (int i = 0; i < N; i++) exp_arr[i] = core_fn(tx[i], mode);
    drain(mode, pat, cycles);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc, s0, mv, any_big;
    bit md;

    vecs[0] = '{val: 0,    len: 3, last_final: 1, exp_range: 0, exp_len: 1, exp_start: 0};
    vecs[1] = '{val: 3328, len: 1, last_final: 1, exp_range: 0, exp_len: 1, exp_start: 0};
    vecs[2] = '{val: 3329, len: 5, last_final: 1, exp_range: 1, exp_len: 1, exp_start: 0};
    vecs[3] = '{val: 4095, len: 2, last_final: 1, exp_range: 1, exp_len: 1, exp_start: 0};
    vecs[4] = '{val: 3330, len: N, last_final: 1, exp_range: 1, exp_len: 0, exp_start: 1};
    vecs[5] = '{val: 100,  len: N, last_final: 0, exp_range: 0, exp_len: 1, exp_start: 1};
    vecs[6] = '{val: 3328, len: N, last_final: 1, exp_range: 0, exp_len: 0, exp_start: 1};

    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; mode_i = 1'b0;
    m_ready_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_vals("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Ramp frame, forward mode, full-rate drain.
    for (int i = 0; i < N; i++) tx[i] = i[W-1:0];
    run_frame(1, 0, 0, 0, cyc);
    check("full-rate drain cycles", cyc, N);
    check("no errors on clean frame (len)", err_len_o, 0);
    check("no errors on clean frame (range)", err_range_o, 0);

    // Same frame, output ready toggling every other cycle.
    run_frame(1, 0, 0, 1, cyc);
    check("backpressured drain cycles", cyc, 2 * N - 1);

    // Early last on beat 9, then a good frame, then clear; finally clear colliding with a new error.
    s0 = n_start;
    send_frame(10, 1, 0, 0);
    repeat (3) @(negedge clk_i);
    check("early last sets err_len_o", err_len_o, 1);
    check("early last gives no core start", n_start - s0, 0);
    check("early last stays idle", busy_o, 0);
    run_frame(1, 0, 1, 2, cyc);
    check("err_len_o sticky across good frame", err_len_o, 1);
    pulse_clr();
    check("err_clr_i clears err_len_o", err_len_o, 0);
    err_clr_i = 1'b1;
    send_frame(1, 1, 0, 0);
    err_clr_i = 1'b0;
    check("set wins over clear", err_len_o, 1);
    pulse_clr();

    // Out-of-range value on beat 5 in inverse mode is stored as-is.
    for (int i = 0; i < N; i++) tx[i] = i[W-1:0];
    tx[5] = 12'd3329;
    run_frame(1, 1, 0, 0, cyc);
    check("err_range_o after 3329", err_range_o, 1);
    check("err_len_o unaffected by range error", err_len_o, 0);
    pulse_clr();

    // Table of single-value frames probing the range and length rules.
    for (int v = 0; v < 7; v++) begin
      pulse_clr();
      for (int b = 0; b < N; b++) tx[b] = b[W-1:0];
      tx[0] = vecs[v].val[W-1:0];
      s0 = n_start;
      if (vecs[v].len == N) run_frame(vecs[v].last_final != 0, 0, 0, 0, cyc);
      else begin
        send_frame(vecs[v].len, vecs[v].last_final != 0, 0, 0);
        repeat (3) @(negedge clk_i);
      end
      check($sformatf("vec%0d core starts", v), n_start - s0, vecs[v].exp_start);
      check($sformatf("vec%0d err_range_o", v), err_range_o, vecs[v].exp_range);
      check($sformatf("vec%0d err_len_o", v), err_len_o, vecs[v].exp_len);
    end
    pulse_clr();

    // Reset while waiting on the core: frame abandoned, late done ignored, next frame clean.
    for (int i = 0; i < N; i++) tx[i] = 12'($urandom_range(0, Q - 1));
    tx[17] = 12'd4000;
    send_frame(N, 1, 1, 0);
    check("pre-reset frame started", core_start_o, 1);
    repeat (2) @(negedge clk_i);
    check("busy in WAIT before reset", busy_o, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_vals("mid-WAIT reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    mv = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i);
      if (m_valid_o !== 1'b0 || busy_o !== 1'b0) mv++;
    end
    check("no output or busy from aborted frame", mv, 0);
    for (int i = 0; i < N; i++) tx[i] = 12'($urandom_range(0, Q - 1));
    run_frame(1, 0, 1, 2, cyc);
    check("post-reset frame clean", err_range_o, 0);

    // Random frames against the frame-level model.
    for (int f = 0; f < 5; f++) begin
      pulse_clr();
      any_big = 0;
      for (int i = 0; i < N; i++) begin
        tx[i] = ($urandom_range(0, 63) == 0) ? 12'($urandom_range(Q, 4095))
                                             : 12'($urandom_range(0, Q - 1));
        if (int'(tx[i]) >= Q) any_big = 1;
      end
      md = 1'($urandom_range(0, 1));
      run_frame(1, md, 1, 2, cyc);
      check($sformatf("rand%0d err_range_o", f), err_range_o, any_big);
      check($sformatf("rand%0d err_len_o", f), err_len_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
